// File: rtl/local_in_port_buffer_pkg.sv
// Shared NoC definitions for the Local input port buffer: packet width,
// packet field offsets and the upstream handshake state encoding.
package local_in_port_buffer_pkg;

    localparam int NOC_DATA_W = 32;

    localparam int X_DST_LSB     = 0;
    localparam int Y_DST_LSB     = 4;
    localparam int X_SRC_LSB     = 8;
    localparam int Y_SRC_LSB     = 12;
    localparam int PACKET_ID_LSB = 16;
    localparam int MODULE_ID_LSB = 24;
    localparam int COORD_W       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLDOFF = 2'd2
    } up_state_t;

    function automatic logic [COORD_W-1:0] pkt_x_dst(input logic [NOC_DATA_W-1:0] pkt);
        return pkt[X_DST_LSB +: COORD_W];
    endfunction

endpackage

// File: rtl/local_in_port_buffer_sync_fifo.sv
// Single-clock FIFO with cleared storage on reset and pass-through on full
// (a push is accepted when full if a pop happens on the same edge).
module sync_fifo #(
    parameter int dataWidth = 32,
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [dataWidth-1:0] din,
    output logic [dataWidth-1:0] dout,
    output logic [PTR_W:0]       count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [dataWidth-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/local_in_port_buffer.sv
// Local input port buffer: injector req/grant handshake feeding a small FIFO
// whose head is presented to the router switch allocator.
module local_in_port_buffer
    import local_in_port_buffer_pkg::*;
#(
    parameter int          dataWidth = NOC_DATA_W,
    parameter int          DEPTH     = 4,
    parameter int          PTR_W     = 2,
    parameter logic [5:0]  routerID  = 6'b000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ReqUpStr,
    input  logic [dataWidth-1:0] PacketIn,
    output logic                 GntUpStr,
    output logic                 UpStrFull,
    output logic                 DataValid,
    output logic [dataWidth-1:0] PacketOut,
    input  logic                 PopDnStr,
    output logic [PTR_W:0]       Occupancy
);

    up_state_t state;
    logic      push;
    logic      accept;
    logic      full;
    logic      empty;

    // A full FIFO can still accept when the head leaves on the same edge.
    assign accept = !full || (PopDnStr && !empty);
    assign push   = (state == IDLE) && ReqUpStr && accept;

    sync_fifo #(
        .dataWidth (dataWidth),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (PopDnStr),
        .din   (PacketIn),
        .dout  (PacketOut),
        .count (Occupancy),
        .full  (full),
        .empty (empty)
    );

    assign UpStrFull = full;
    assign DataValid = !empty;

    // GRANT and HOLDOFF ignore Req: the injector still holds it while it
    // samples the grant, so accepting here would double-write the packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            GntUpStr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    GntUpStr <= push;
                    if (push) state <= GRANT;
                end
                GRANT: begin
                    GntUpStr <= 1'b0;
                    state    <= HOLDOFF;
                end
                default: begin
                    GntUpStr <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            if (push) $display("LocalIn_Log_%b: %0t write %h", routerID, $time, PacketIn);
            if (PopDnStr && !empty) $display("LocalIn_Log_%b: %0t pop %h", routerID, $time, PacketOut);
        end
    end
`endif

endmodule

// File: tb/tb_local_in_port_buffer.sv
// Scoreboard bench for local_in_port_buffer: a cycle model predicts each edge
// from the driven inputs; the FIFO contents queue is checked against the DUT.
module tb_local_in_port_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqUpStr;
    logic [31:0] PacketIn;
    logic        GntUpStr;
    logic        UpStrFull;
    logic        DataValid;
    logic [31:0] PacketOut;
    logic        PopDnStr;
    logic [2:0]  Occupancy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          written     = 0;
    int          delivered   = 0;
    bit          soak        = 1'b0;

    logic [31:0] q[$];
    int          m_state = 0;
    bit          m_gnt   = 1'b0;

    local_in_port_buffer #(
        .dataWidth (32),
        .DEPTH     (4),
        .PTR_W     (2),
        .routerID  (6'b000_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqUpStr  (ReqUpStr),
        .PacketIn  (PacketIn),
        .GntUpStr  (GntUpStr),
        .UpStrFull (UpStrFull),
        .DataValid (DataValid),
        .PacketOut (PacketOut),
        .PopDnStr  (PopDnStr),
        .Occupancy (Occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock edge: predict from the model, advance, then compare at negedge.
    task automatic tick();
        bit pop_ok;
        bit wr_ok;
        if (soak) PopDnStr = ($urandom_range(0, 2) == 0);
        pop_ok = PopDnStr && (q.size() > 0);
        wr_ok  = (m_state == 0) && ReqUpStr && ((q.size() < 4) || pop_ok);
        @(posedge clk);
        if (pop_ok) begin
            void'(q.pop_front());
            delivered++;
        end
        if (wr_ok) begin
            q.push_back(PacketIn);
            written++;
        end
        m_gnt   = wr_ok;
        m_state = wr_ok ? 1 : ((m_state == 1) ? 2 : 0);
        @(negedge clk);
        check("gnt",   {31'd0, GntUpStr},  {31'd0, m_gnt});
        check("occ",   {29'd0, Occupancy}, q.size());
        check("valid", {31'd0, DataValid}, (q.size() != 0) ? 32'd1 : 32'd0);
        check("full",  {31'd0, UpStrFull}, (q.size() == 4) ? 32'd1 : 32'd0);
        if (q.size() != 0) check("head", PacketOut, q[0]);
    endtask

    // Injector: hold Req until Gnt is seen, keep it through the grant edge, drop.
    task automatic send_pkt(input logic [31:0] p, input int max_wait);
        int waited = 0;
        PacketIn = p;
        ReqUpStr = 1'b1;
        while (1) begin
            tick();
            if (GntUpStr) break;
            waited++;
            if (waited >= max_wait) begin
                check("grant_timeout", 32'd0, 32'd1);
                ReqUpStr = 1'b0;
                return;
            end
        end
        tick();
        ReqUpStr = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        ReqUpStr = 1'b1;
        PacketIn = 32'hDEAD_BEEF;
        PopDnStr = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst_gnt",   {31'd0, GntUpStr},  32'd0);
            check("rst_valid", {31'd0, DataValid}, 32'd0);
            check("rst_full",  {31'd0, UpStrFull}, 32'd0);
            check("rst_occ",   {29'd0, Occupancy}, 32'd0);
            check("rst_data",  PacketOut,          32'd0);
        end
        ReqUpStr = 1'b0;
        reset    = 1'b1;
        repeat (2) tick();

        // Single packet, then Req ignored across GRANT/HOLDOFF
        send_pkt(32'h0001_2345, 10);
        tick();
        tick();
        PopDnStr = 1'b1;
        tick();
        PopDnStr = 1'b0;

        // Fill to full, fifth request stalls, then a pop lets it through
        for (int i = 1; i <= 4; i++) send_pkt(32'hA000_0000 + i, 10);
        tick();
        PacketIn = 32'hA000_0005;
        ReqUpStr = 1'b1;
        repeat (10) tick();
        PopDnStr = 1'b1;
        tick();
        PopDnStr = 1'b0;
        tick();
        ReqUpStr = 1'b0;
        tick();

        // Pass-through on full: write and pop on the same edge
        PacketIn = 32'hA000_0006;
        ReqUpStr = 1'b1;
        PopDnStr = 1'b1;
        tick();
        PopDnStr = 1'b0;
        tick();
        ReqUpStr = 1'b0;
        tick();

        PopDnStr = 1'b1;
        repeat (6) tick();

        // Pops on an empty FIFO must change nothing
        repeat (3) tick();
        PopDnStr = 1'b0;
        send_pkt(32'hB000_0001, 10);
        send_pkt(32'hB000_0002, 10);
        tick();
        PopDnStr = 1'b1;
        repeat (3) tick();
        PopDnStr = 1'b0;

        // Soak with random pop gaps across many pointer wraps
        soak = 1'b1;
        for (int i = 0; i < 1023; i++) send_pkt($urandom, 40);
        soak     = 1'b0;
        PopDnStr = 1'b1;
        repeat (8) tick();
        PopDnStr = 1'b0;
        check("delivered", delivered, written);
        check("drained",   {29'd0, Occupancy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
